t_vpi_rw_bank: RTL

Parametrised VPI read/write target for the regression suite: a bank of `NCH` public registers of `WIDTH` bits that the C++ VPI monitor writes through `vpi_put_value` and hands over with a request/acknowledge flag. The block captures each handed-over round, checks it against a deterministic expected pattern, and reports pass/fail. It supersedes the single-bit public register test with multi-channel, multi-round, width-generic coverage and a timeout path.

---
 rtl/t_vpi_rw_pkg.sv | 35 +++
 rtl/t_vpi_rw_bank_chk.sv | 54 +++++
 rtl/t_vpi_rw_bank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/t_vpi_rw_pkg.sv
// -----------------------------------------------------------------------------
// t_vpi_rw_pkg
// Shared definitions for the VPI read/write register bank:
//   - state_t : handover FSM states
//   - ERR_W   : width of the saturating error counter
//   - exp_val : expected channel value for a given round and channel index
// -----------------------------------------------------------------------------
package t_vpi_rw_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_REQ = 3'd2,
    S_CAPTURE  = 3'd3,
    S_CHECK    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int ERR_W = 8;

  // Expected pattern: (rnd*nch + idx + 1) truncated to 'width' bits.
  // Computed at 64 bits so every legal width shares one implementation.
  function automatic logic [63:0] exp_val(input logic [7:0]  rnd,
                                          input int unsigned idx,
                                          input int unsigned width,
                                          input int unsigned nch);
    logic [63:0] sum;
    logic [63:0] mask;
    sum = 64'(rnd) * 64'(nch) + 64'(idx) + 64'd1;
    if (width >= 64) mask = '1;
    else             mask = (64'd1 << width) - 64'd1;
    return sum & mask;
  endfunction

endpackage

// File: rtl/t_vpi_rw_bank_chk.sv
// -----------------------------------------------------------------------------
// t_vpi_rw_chk
// Sequential per-channel comparator with a saturating error counter. The FSM
// presents one captured channel per cycle (i_idx / i_data) while i_en is high;
// each mismatch against the expected pattern bumps the counter. i_tmo adds one
// for a handover timeout. The counter sticks at its maximum.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_en          compare i_data this cycle
//   i_idx         channel index being compared
//   i_round       current round number
//   i_data        captured channel value
//   i_tmo         timeout event (one cycle)
//   o_err_cnt     saturating error count
// -----------------------------------------------------------------------------
module t_vpi_rw_chk
  import t_vpi_rw_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [7:0]       i_round,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_tmo,
  output logic [ERR_W-1:0] o_err_cnt
);

  logic [63:0]      w_exp;
  logic             w_mis;
  logic             w_inc;
  logic [ERR_W-1:0] r_err;

  assign w_exp = exp_val(i_round, 32'(i_idx), WIDTH, NCH);
  // exp_val is already truncated to WIDTH, so a zero-extended compare is exact.
  assign w_mis = i_en && (64'(i_data) != w_exp);
  // Compare and timeout never occur in the same cycle (different FSM states).
  assign w_inc = w_mis || i_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (w_inc && (r_err != '1)) begin
      r_err <= r_err + ERR_W'(1);
    end
  end

  assign o_err_cnt = r_err;

endmodule

// File: rtl/t_vpi_rw_bank.sv
// -----------------------------------------------------------------------------
// t_vpi_rw_bank
// VPI read/write target: NCH public registers of WIDTH bits (chan_data) plus a
// request flag (req) are deposited by an external VPI monitor. Each handed-over
// round is captured, compared channel by channel against the expected pattern,
// and a pass/fail verdict is reported after ROUNDS rounds or on a timeout.
// Public to the monitor: chan_data, req (read/write); ack, round (read-only).
// Optional build macro T_VPI_RW_SHADOW_EN adds 'shadow', holding the bitwise
// inverse of chan_data as captured, so the monitor can verify its read path.
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous reset, active-high
//   start    begin the test (only honoured in IDLE)
//   rd_chan  capture-bank read index
//   rd_data  registered capture-bank readback (0 for rd_chan >= NCH)
//   done     sticky completion flag
//   pass     sticky verdict, valid with done
//   err_cnt  saturating mismatch/timeout count
// -----------------------------------------------------------------------------
module t_vpi_rw_bank
  import t_vpi_rw_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NCH     = 4,
  parameter  int ROUNDS  = 3,
  parameter  int TIMEOUT = 1000,
  localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] rd_chan,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCH - 1);
  localparam logic [7:0]       LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] TMO_VAL    = CNT_W'(TIMEOUT);

  // Monitor-visible registers
  logic [WIDTH-1:0] chan_data [NCH];
  logic             req;
  logic             ack;
  logic [7:0]       round;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_cap [NCH];
  logic [WIDTH-1:0] r_rd_data;

  logic             w_cap_en, w_chk_en, w_tmo, w_done;
  logic             w_last, w_tmo_hit;
  logic [WIDTH-1:0] w_chk_data;
  logic [WIDTH-1:0] w_rd_terms [NCH];
  logic [WIDTH-1:0] w_rd_mux;
  logic [ERR_W-1:0] w_err_cnt;

  assign w_last    = (r_idx == LAST_IDX);
  assign w_tmo_hit = (r_cnt == TMO_VAL);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_next = S_ARM;
      S_ARM:      w_state_next = S_WAIT_REQ;
      // A pending request beats a timeout expiring in the same cycle.
      S_WAIT_REQ: if (req)            w_state_next = S_CAPTURE;
                  else if (w_tmo_hit) w_state_next = S_DONE;
      S_CAPTURE:  w_state_next = S_CHECK;
      S_CHECK:    if (w_last) w_state_next = (round == LAST_ROUND) ? S_DONE : S_ARM;
      S_DONE:     w_state_next = S_DONE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ack      = 1'b0;
    w_cap_en = 1'b0;
    w_chk_en = 1'b0;
    w_tmo    = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_WAIT_REQ: w_tmo = !req && w_tmo_hit;
      S_CAPTURE:  begin ack = 1'b1; w_cap_en = 1'b1; end
      S_CHECK:    w_chk_en = 1'b1;
      S_DONE:     w_done = 1'b1;
      default:    ;
    endcase
    done = w_done;
    pass = w_done && (w_err_cnt == '0);
  end

  // Plain always (not always_ff): the monitor also deposits into these
  // registers from outside. The block only resets them and clears req on
  // capture; a monitor write of req during CAPTURE is overwritten by the clear.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      req <= 1'b0;
      for (int k = 0; k < NCH; k++) chan_data[k] <= '0;
    end else if (w_cap_en) begin
      req <= 1'b0;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      round <= '0;
      for (int k = 0; k < NCH; k++) r_cap[k] <= '0;
    end else begin
      case (r_state)
        S_ARM:      r_cnt <= '0;
        S_WAIT_REQ: if (!w_tmo_hit) r_cnt <= r_cnt + CNT_W'(1);
        S_CAPTURE: begin
          r_idx <= '0;
          for (int k = 0; k < NCH; k++) r_cap[k] <= chan_data[k];
        end
        S_CHECK: begin
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
          if (w_last) round <= round + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef T_VPI_RW_SHADOW_EN
  logic [WIDTH-1:0] shadow [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= '0;
    end else if (w_cap_en) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= ~chan_data[k];
    end
  end
`else
`endif

  // Readback: one-hot select terms ORed together; indices >= NCH match no
  // term and read as zero.
  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_rd
    assign w_rd_terms[gi] = (rd_chan == IDX_W'(gi)) ? r_cap[gi] : '0;
  end

  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NCH; k++) w_rd_mux = w_rd_mux | w_rd_terms[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_rd_mux;
  end

  assign rd_data    = r_rd_data;
  assign w_chk_data = r_cap[r_idx];
  assign err_cnt    = w_err_cnt;

  t_vpi_rw_chk #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_chk_en),
    .i_idx     (r_idx),
    .i_round   (round),
    .i_data    (w_chk_data),
    .i_tmo     (w_tmo),
    .o_err_cnt (w_err_cnt)
  );

endmodule
